eth_mdio_resp: RTL and testbench

Clause-22 MDIO responder (PHY-side management slave) for the MDC clock domain. It decodes read and write frames issued by the team's MDIO master, holds a 32 x 16 PHY register file, and drives read data back on the shared line. It serves as the PHY model in loopback and regression benches, and as the management endpoint when the fabric emulates a PHY.

---
 rtl/eth_mdio_resp.sv | 227 ++++++++++++++++++++++
 tb/tb_eth_mdio_resp.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/eth_mdio_resp.sv
// Clause-22 MDIO responder with a 32 x 16 PHY register file, clocked by MDC.
// Optional build macro: MDIO_RESP_PRE_SUPPRESS_EN (accepts frames with a shortened preamble).
module eth_mdio_resp #(
    parameter logic [4:0]  pPhy_Addr = 5'd1,
    parameter logic [15:0] pPhy_Id1  = 16'h0007,
    parameter logic [15:0] pPhy_Id2  = 16'hC0F1
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        MDIO_In,
    output logic        MDIO_Out,
    output logic        MDIO_Oe,
    output logic        Reg_Wr_Strobe,
    output logic [4:0]  Reg_Wr_Addr,
    output logic [15:0] Reg_Wr_Data,
    output logic        Frame_Err
);

    // state  | meaning
    // IDLE   | counting preamble ones, waiting for the ST leading 0
    // ST     | expecting the ST trailing 1
    // OP     | collecting the 2 opcode bits
    // PHY    | collecting PHYAD[4:0]
    // REG    | collecting REGAD[4:0]; last edge snapshots read data
    // TA     | two turnaround cycles
    // DATA   | 16 data cycles, commit of a write on the last one
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_ST   = 3'd1;
    localparam logic [2:0] S_OP   = 3'd2;
    localparam logic [2:0] S_PHY  = 3'd3;
    localparam logic [2:0] S_REG  = 3'd4;
    localparam logic [2:0] S_TA   = 3'd5;
    localparam logic [2:0] S_DATA = 3'd6;

    localparam logic [15:0] REG0_RST = 16'h3100;
`ifdef MDIO_RESP_PRE_SUPPRESS_EN
    localparam logic [15:0] REG1_VAL = 16'h786D;
`else
    localparam logic [15:0] REG1_VAL = 16'h782D;
`endif

    logic [2:0]  state;
    logic [3:0]  bit_cnt;
    logic [5:0]  pre_cnt;
    logic        op_hi;
    logic        is_read;
    logic        match;
    logic        ta_bad;
    logic [3:0]  phyad;
    logic [4:0]  regad;
    logic [14:0] rx_shift;
    logic [15:0] tx_shift;
    logic [15:0] regs [32];

    logic        pre_ok;
    logic [4:0]  rd_addr;
    logic [15:0] rd_data;
    logic [15:0] wr_data;
    logic        wr_writable;
    logic        wr_commit;
    logic        drive;

`ifdef MDIO_RESP_PRE_SUPPRESS_EN
    assign pre_ok = (pre_cnt != 6'd0);
`else
    assign pre_ok = (pre_cnt == 6'd32);
`endif

    assign drive       = is_read && match;
    assign wr_data     = {rx_shift, MDIO_In};
    assign wr_writable = (regad == 5'd0) || (regad >= 5'd4);
    assign wr_commit   = (state == S_DATA) && (bit_cnt == 4'd0) && !is_read
                         && match && !ta_bad && wr_writable;

    always_comb begin
        rd_addr = {regad[3:0], MDIO_In};
        case (rd_addr)
            5'd1:    rd_data = REG1_VAL;
            5'd2:    rd_data = pPhy_Id1;
            5'd3:    rd_data = pPhy_Id2;
            default: rd_data = regs[rd_addr];
        endcase
    end

    // Bit 15 of reg 0 is a soft reset and is never stored.
    always_ff @(posedge Clk) begin
        if (Rst || (wr_commit && regad == 5'd0 && wr_data[15])) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= '0;
            end
            regs[0] <= REG0_RST;
        end else if (wr_commit) begin
            regs[regad] <= wr_data;
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state         <= S_IDLE;
            bit_cnt       <= '0;
            pre_cnt       <= '0;
            op_hi         <= 1'b0;
            is_read       <= 1'b0;
            match         <= 1'b0;
            ta_bad        <= 1'b0;
            phyad         <= '0;
            regad         <= '0;
            rx_shift      <= '0;
            tx_shift      <= '0;
            MDIO_Out      <= 1'b1;
            MDIO_Oe       <= 1'b0;
            Reg_Wr_Strobe <= 1'b0;
            Reg_Wr_Addr   <= '0;
            Reg_Wr_Data   <= '0;
            Frame_Err     <= 1'b0;
        end else begin
            Frame_Err     <= 1'b0;
            Reg_Wr_Strobe <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (MDIO_In) begin
                        if (pre_cnt != 6'd32) begin
                            pre_cnt <= pre_cnt + 6'd1;
                        end
                    end else begin
                        pre_cnt <= '0;
                        if (pre_ok) begin
                            state <= S_ST;
                        end
                    end
                end
                S_ST: begin
                    if (MDIO_In) begin
                        state   <= S_OP;
                        bit_cnt <= 4'd1;
                    end else begin
                        Frame_Err <= 1'b1;
                        state     <= S_IDLE;
                    end
                end
                S_OP: begin
                    if (bit_cnt != 4'd0) begin
                        op_hi   <= MDIO_In;
                        bit_cnt <= 4'd0;
                    end else if (op_hi != MDIO_In) begin
                        is_read <= op_hi;
                        state   <= S_PHY;
                        bit_cnt <= 4'd4;
                    end else begin
                        Frame_Err <= 1'b1;
                        state     <= S_IDLE;
                    end
                end
                S_PHY: begin
                    phyad <= {phyad[2:0], MDIO_In};
                    if (bit_cnt == 4'd0) begin
                        match   <= ({phyad, MDIO_In} == pPhy_Addr);
                        state   <= S_REG;
                        bit_cnt <= 4'd4;
                    end else begin
                        bit_cnt <= bit_cnt - 4'd1;
                    end
                end
                S_REG: begin
                    regad <= rd_addr;
                    if (bit_cnt == 4'd0) begin
                        state    <= S_TA;
                        bit_cnt  <= 4'd1;
                        ta_bad   <= 1'b0;
                        tx_shift <= rd_data;
                    end else begin
                        bit_cnt <= bit_cnt - 4'd1;
                    end
                end
                S_TA: begin
                    if (bit_cnt != 4'd0) begin
                        bit_cnt <= 4'd0;
                        if (drive) begin
                            MDIO_Oe  <= 1'b1;
                            MDIO_Out <= 1'b0;
                        end
                        if (!is_read && match && !MDIO_In) begin
                            ta_bad    <= 1'b1;
                            Frame_Err <= 1'b1;
                        end
                    end else begin
                        state   <= S_DATA;
                        bit_cnt <= 4'd15;
                        if (drive) begin
                            MDIO_Out <= tx_shift[15];
                            tx_shift <= {tx_shift[14:0], 1'b0};
                        end
                        if (!is_read && match && !ta_bad && MDIO_In) begin
                            ta_bad    <= 1'b1;
                            Frame_Err <= 1'b1;
                        end
                    end
                end
                S_DATA: begin
                    rx_shift <= wr_data[14:0];
                    if (bit_cnt != 4'd0) begin
                        bit_cnt <= bit_cnt - 4'd1;
                        if (drive) begin
                            MDIO_Out <= tx_shift[15];
                            tx_shift <= {tx_shift[14:0], 1'b0};
                        end
                    end else begin
                        state    <= S_IDLE;
                        pre_cnt  <= '0;
                        MDIO_Oe  <= 1'b0;
                        MDIO_Out <= 1'b1;
                        if (wr_commit) begin
                            Reg_Wr_Strobe <= 1'b1;
                            Reg_Wr_Addr   <= regad;
                            Reg_Wr_Data   <= wr_data;
                        end
                    end
                end
                default: begin
                    state   <= S_IDLE;
                    pre_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_eth_mdio_resp.sv
// Directed bench for eth_mdio_resp acting as the MDIO master.
// Expectations follow MDIO_RESP_PRE_SUPPRESS_EN when it is defined for the build.
module tb_eth_mdio_resp;

    logic        clk = 1'b0;
    logic        rst;
    logic        drv;
    logic        mdio_in;
    logic        mdio_out;
    logic        mdio_oe;
    logic        wr_strobe;
    logic [4:0]  wr_addr;
    logic [15:0] wr_data;
    logic        frame_err;

    int checks = 0;
    int errors = 0;
    int strobe_cnt = 0;
    int ferr_cnt = 0;
    int oe_cnt = 0;

    logic [15:0] rd;
    logic        ta_ok;

`ifdef MDIO_RESP_PRE_SUPPRESS_EN
    localparam logic [31:0] EXP_REG1   = 32'h786D;
    localparam logic [31:0] EXP_OE_31  = 32'd17;
`else
    localparam logic [31:0] EXP_REG1   = 32'h782D;
    localparam logic [31:0] EXP_OE_31  = 32'd0;
`endif

    always #5 clk = ~clk;

    // Line model: responder wins when it drives, otherwise the master value.
    assign mdio_in = mdio_oe ? mdio_out : drv;

    eth_mdio_resp #(
        .pPhy_Addr (5'd1),
        .pPhy_Id1  (16'h0007),
        .pPhy_Id2  (16'hC0F1)
    ) dut (
        .Clk           (clk),
        .Rst           (rst),
        .MDIO_In       (mdio_in),
        .MDIO_Out      (mdio_out),
        .MDIO_Oe       (mdio_oe),
        .Reg_Wr_Strobe (wr_strobe),
        .Reg_Wr_Addr   (wr_addr),
        .Reg_Wr_Data   (wr_data),
        .Frame_Err     (frame_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        @(negedge clk);
        drv = b;
        @(posedge clk);
        #1;
        if (wr_strobe) strobe_cnt++;
        if (frame_err) ferr_cnt++;
        if (mdio_oe) oe_cnt++;
    endtask

    task automatic send_bits(input logic [31:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            send_bit(v[i]);
        end
    endtask

    task automatic header(input int pre, input logic [1:0] op, input logic [4:0] phy,
                          input logic [4:0] ra);
        send_bits(32'hFFFF_FFFF, pre);
        send_bits(32'b01, 2);
        send_bits({30'b0, op}, 2);
        send_bits({27'b0, phy}, 5);
        send_bits({27'b0, ra}, 5);
    endtask

    task automatic do_read(input int pre, input logic [4:0] phy, input logic [4:0] ra,
                           input int abort_k, output logic [15:0] data, output logic ta_drv);
        data   = '0;
        ta_drv = 1'b0;
        oe_cnt = 0;
        header(pre, 2'b10, phy, ra);
        for (int k = 1; k <= 18; k++) begin
            if (k == abort_k) begin
                @(negedge clk);
                rst = 1'b1;
                drv = 1'b1;
                @(posedge clk);
                #1;
                check("oe_on_reset_edge", {31'b0, mdio_oe}, 32'd0);
                @(negedge clk);
                rst = 1'b0;
                return;
            end
            send_bit(1'b1);
            if (k == 1) ta_drv = mdio_oe && !mdio_out;
            else if (k <= 17) data = {data[14:0], mdio_out};
        end
    endtask

    task automatic do_write(input logic [4:0] phy, input logic [4:0] ra, input logic [15:0] d);
        strobe_cnt = 0;
        ferr_cnt   = 0;
        header(32, 2'b01, phy, ra);
        send_bits(32'b10, 2);
        send_bits({16'h0, d}, 16);
        send_bit(1'b1);
    endtask

    initial begin
        rst = 1'b1;
        drv = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out",    {31'b0, mdio_out},  32'd1);
        check("rst_oe",     {31'b0, mdio_oe},   32'd0);
        check("rst_strobe", {31'b0, wr_strobe}, 32'd0);
        check("rst_addr",   {27'b0, wr_addr},   32'd0);
        check("rst_data",   {16'b0, wr_data},   32'd0);
        check("rst_ferr",   {31'b0, frame_err}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        do_read(32, 5'd1, 5'd2, 0, rd, ta_ok);
        check("rd_reg2",      {16'b0, rd},     32'h0007);
        check("rd_reg2_ta",   {31'b0, ta_ok},  32'd1);
        check("rd_reg2_oe",   oe_cnt,          32'd17);
        do_read(32, 5'd1, 5'd3, 0, rd, ta_ok);
        check("rd_reg3",      {16'b0, rd},     32'hC0F1);
        do_read(32, 5'd1, 5'd1, 0, rd, ta_ok);
        check("rd_reg1",      {16'b0, rd},     EXP_REG1);
        do_read(32, 5'd1, 5'd0, 0, rd, ta_ok);
        check("rd_reg0",      {16'b0, rd},     32'h3100);

        do_write(5'd1, 5'd4, 16'hBEEF);
        check("wr4_strobes",  strobe_cnt,      32'd1);
        check("wr4_addr",     {27'b0, wr_addr}, 32'd4);
        check("wr4_data",     {16'b0, wr_data}, 32'hBEEF);
        check("wr4_ferr",     ferr_cnt,        32'd0);
        do_read(32, 5'd1, 5'd4, 0, rd, ta_ok);
        check("rd_reg4",      {16'b0, rd},     32'hBEEF);

        do_read(32, 5'd2, 5'd2, 0, rd, ta_ok);
        check("phy2_no_drive", oe_cnt,         32'd0);
        do_read(32, 5'd1, 5'd2, 0, rd, ta_ok);
        check("after_phy2_rd", {16'b0, rd},    32'h0007);
        check("after_phy2_oe", oe_cnt,         32'd17);

        do_read(31, 5'd1, 5'd2, 0, rd, ta_ok);
        check("pre31_oe",     oe_cnt,          EXP_OE_31);

        ferr_cnt = 0;
        oe_cnt   = 0;
        send_bits(32'hFFFF_FFFF, 32);
        send_bits(32'b01, 2);
        send_bit(1'b1);
        send_bit(1'b1);
        check("op11_ferr_now", {31'b0, frame_err}, 32'd1);
        send_bits(32'hFFFF_FFFF, 12);
        check("op11_ferr_cnt", ferr_cnt,       32'd1);
        check("op11_no_drive", oe_cnt,         32'd0);
        do_read(32, 5'd1, 5'd2, 0, rd, ta_ok);
        check("after_op11_rd", {16'b0, rd},    32'h0007);

        strobe_cnt = 0;
        ferr_cnt   = 0;
        header(32, 2'b01, 5'd1, 5'd5);
        send_bit(1'b1);
        send_bit(1'b1);
        check("ta_bad_ferr_now", {31'b0, frame_err}, 32'd1);
        send_bits(32'h0000_5A5A, 16);
        send_bit(1'b1);
        check("ta_bad_ferr_cnt", ferr_cnt,     32'd1);
        check("ta_bad_no_strobe", strobe_cnt,  32'd0);
        do_read(32, 5'd1, 5'd5, 0, rd, ta_ok);
        check("ta_bad_reg5",  {16'b0, rd},     32'h0000);

        do_write(5'd1, 5'd0, 16'h1140);
        do_read(32, 5'd1, 5'd0, 0, rd, ta_ok);
        check("rd_reg0_1140", {16'b0, rd},     32'h1140);
        do_write(5'd1, 5'd0, 16'h8000);
        check("srst_strobes", strobe_cnt,      32'd1);
        check("srst_addr",    {27'b0, wr_addr}, 32'd0);
        check("srst_data",    {16'b0, wr_data}, 32'h8000);
        do_read(32, 5'd1, 5'd0, 0, rd, ta_ok);
        check("srst_reg0",    {16'b0, rd},     32'h3100);
        do_read(32, 5'd1, 5'd4, 0, rd, ta_ok);
        check("srst_reg4",    {16'b0, rd},     32'h0000);

        do_write(5'd1, 5'd2, 16'h1234);
        check("ro_no_strobe", strobe_cnt,      32'd0);
        check("ro_no_ferr",   ferr_cnt,        32'd0);
        check("ro_data_hold", {16'b0, wr_data}, 32'h8000);
        do_read(32, 5'd1, 5'd2, 0, rd, ta_ok);
        check("ro_reg2",      {16'b0, rd},     32'h0007);

        do_write(5'd1, 5'd4, 16'hBEEF);
        check("pre_rst_wr4",  {16'b0, wr_data}, 32'hBEEF);
        do_read(32, 5'd1, 5'd4, 8, rd, ta_ok);
        check("hrst_addr",    {27'b0, wr_addr}, 32'd0);
        check("hrst_data",    {16'b0, wr_data}, 32'h0000);
        do_read(32, 5'd1, 5'd4, 0, rd, ta_ok);
        check("hrst_reg4",    {16'b0, rd},     32'h0000);
        check("hrst_reg4_oe", oe_cnt,          32'd17);
        do_read(32, 5'd1, 5'd0, 0, rd, ta_ok);
        check("hrst_reg0",    {16'b0, rd},     32'h3100);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
